// File: rtl/mem_access_unit.sv
// Memory-stage bus master: checks addresses against a region map, runs one req/ready
// bus transaction per load/store, extends load data and owns the M->W pipeline register.
module mem_access_unit #(
  parameter int                    NUM_REG      = 4,
  parameter logic [NUM_REG*32-1:0] REG_BASE     = {32'h7f20, 32'h7f10, 32'h7f00, 32'h0},
  parameter logic [NUM_REG*32-1:0] REG_LIMIT    = {32'h7f23, 32'h7f1b, 32'h7f0b, 32'h2fff},
  parameter logic [NUM_REG-1:0]    REG_WORDONLY = 4'b1110,
  parameter logic [NUM_REG-1:0]    REG_RDONLY   = 4'b0000,
  parameter int                    TIMEOUT      = 16,
  parameter logic [4:0]            EXC_ADEL     = 5'd4,
  parameter logic [4:0]            EXC_ADES     = 5'd5,
  parameter logic [4:0]            EXC_DBE      = 5'd7,
  parameter logic [31:0]           RESET_PC     = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_ovf,
  input  logic [4:0]  m_exc_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        m_stall,
  output logic [4:0]  m_exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [31:0] w_rdata,
  output logic [4:0]  w_exc,
  output logic        dbg_state
);

  // Bus handshake: bus_req stays high with stable addr/be/wdata/we from the cycle after
  // start until the cycle bus_ready is seen (or the timeout cycle); that cycle completes it.

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;
  logic [31:0]      flush_pc_q;
  logic [31:0]      pc_q;
  logic [3:0]       op_q;
  logic [1:0]       addr_lo_q;

  logic        is_load, is_store, is_mem, is_byte, is_half, is_word;
  logic        hit, hit_wo, hit_ro, misalign, addr_err;
  logic        start, busy, timeout_hit, done;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane_shift;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  always_comb begin
    is_load  = (m_op >= OP_LB) && (m_op <= OP_LW);
    is_store = (m_op >= OP_SB) && (m_op <= OP_SW);
    is_mem   = is_load || is_store;
    is_byte  = (m_op == OP_LB) || (m_op == OP_LBU) || (m_op == OP_SB);
    is_half  = (m_op == OP_LH) || (m_op == OP_LHU) || (m_op == OP_SH);
    is_word  = (m_op == OP_LW) || (m_op == OP_SW);
  end

  // Scan high to low so the lowest matching region index is the one that sticks.
  always_comb begin
    hit    = 1'b0;
    hit_wo = 1'b0;
    hit_ro = 1'b0;
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if ((m_addr >= REG_BASE[i*32 +: 32]) && (m_addr <= REG_LIMIT[i*32 +: 32])) begin
        hit    = 1'b1;
        hit_wo = REG_WORDONLY[i];
        hit_ro = REG_RDONLY[i];
      end
    end
  end

  always_comb begin
    misalign = (is_half && m_addr[0]) || (is_word && (m_addr[1:0] != 2'b00));
    addr_err = misalign || !hit || (hit_wo && !is_word) || m_ovf || (is_store && hit_ro);
    m_exc    = 5'd0;
    if (m_exc_in != 5'd0)
      m_exc = m_exc_in;
    else if (is_store && addr_err)
      m_exc = EXC_ADES;
    else if (is_load && addr_err)
      m_exc = EXC_ADEL;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = m_wdata;
    if (is_byte) begin
      be_d    = 4'b0001 << m_addr[1:0];
      wdata_d = {24'b0, m_wdata[7:0]} << {m_addr[1:0], 3'b000};
    end else if (is_half) begin
      be_d    = m_addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = m_addr[1] ? {m_wdata[15:0], 16'b0} : {16'b0, m_wdata[15:0]};
    end
  end

  always_comb begin
    busy        = (state == BUSY);
    start       = !busy && m_valid && is_mem && (m_exc == 5'd0) && !flush;
    timeout_hit = busy && !bus_ready && (cnt == CNT_W'(TIMEOUT - 1));
    done        = busy && (bus_ready || timeout_hit);
    m_stall     = start || (busy && !bus_ready && !timeout_hit);
    state_d     = state;
    if (start)
      state_d = BUSY;
    else if (done)
      state_d = IDLE;
  end

  assign bus_req   = busy;
  assign dbg_state = busy;

  always_comb begin
    lane_shift = bus_rdata >> {addr_lo_q, 3'b000};
    half_lane  = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{lane_shift[7]}}, lane_shift[7:0]};
      OP_LBU:  load_ext = {24'b0, lane_shift[7:0]};
      OP_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_ext = {16'b0, half_lane};
      OP_LW:   load_ext = bus_rdata;
      default: load_ext = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      flush_pc_q <= 32'b0;
      pc_q       <= 32'b0;
      op_q       <= 4'b0;
      addr_lo_q  <= 2'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'b0;
      bus_be     <= 4'b0;
      bus_wdata  <= 32'b0;
    end else begin
      state <= state_d;
      if (start) begin
        cnt       <= '0;
        pc_q      <= m_pc;
        op_q      <= m_op;
        addr_lo_q <= m_addr[1:0];
        bus_we    <= is_store;
        bus_addr  <= {m_addr[31:2], 2'b00};
        bus_be    <= be_d;
        bus_wdata <= wdata_d;
      end else if (done) begin
        bus_we     <= 1'b0;
        flush_pend <= 1'b0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        // The first flush seen during a transaction owns the handler PC.
        if (flush && !flush_pend) begin
          flush_pend <= 1'b1;
          flush_pc_q <= flush_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_valid <= 1'b0;
      w_pc    <= RESET_PC;
      w_rdata <= 32'b0;
      w_exc   <= 5'd0;
    end else if (!m_stall) begin
      if (busy) begin
        if (flush_pend || flush) begin
          w_valid <= 1'b0;
          w_pc    <= flush_pend ? flush_pc_q : flush_pc;
          w_rdata <= 32'b0;
          w_exc   <= 5'd0;
        end else begin
          w_valid <= 1'b1;
          w_pc    <= pc_q;
          w_rdata <= bus_ready ? load_ext : 32'b0;
          w_exc   <= bus_ready ? 5'd0 : EXC_DBE;
        end
      end else if (flush) begin
        w_valid <= 1'b0;
        w_pc    <= flush_pc;
        w_rdata <= 32'b0;
        w_exc   <= 5'd0;
      end else begin
        w_valid <= m_valid;
        w_pc    <= m_pc;
        w_rdata <= 32'b0;
        w_exc   <= m_valid ? m_exc : 5'd0;
      end
    end
  end

endmodule
